readout_sequencer: RTL and testbench
====================================

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameter NSLOTS, default 8: number of slots scanned per event, range 1..255.
REQ-002 Parameter FIRST_SLOT, default 0: slot number of the first slot scanned; FIRST_SLOT+NSLOTS-1 SHALL be at most 254.
REQ-003 Parameter SETTLE, default 2: bus settle cycles between an addr change and the data sample, range 1..15.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 trig  in  1  single-cycle event trigger that starts one scan.
REQ-007 clr_ovr  in  1  clears the overrun flag.
REQ-008 addr  out  8  slot address driven to the shared readout bus.
REQ-009 bus_data  in  16  shared tristate data bus from the slot modules.
REQ-010 out_data  out  16  captured word.
REQ-011 out_slot  out  8  slot number of out_data.
REQ-012 out_valid  out  1  out_data/out_slot are valid.
REQ-013 out_ready  in  1  downstream accepts the word.
REQ-014 out_last  out  1  marks the final word of an event.
REQ-015 busy  out  1  a scan is in progress.
REQ-016 overrun  out  1  sticky flag: a trigger arrived while busy.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, SAMPLE, PRESENT and, when enabled, TRAILER.
REQ-018 In IDLE, addr SHALL be 8'hFF, which no slot matches, so the bus floats.
REQ-019 IDLE->SELECT on trig: addr SHALL be FIRST_SLOT on the next cycle, the settle counter loads SETTLE, and busy=1.
REQ-020 SELECT SHALL decrement the settle counter; at count 1 -> SAMPLE.
REQ-021 SAMPLE SHALL register bus_data into out_data and addr into out_slot, then -> PRESENT.
REQ-022 Latency: trig high in cycle 0 SHALL give out_valid=1 in cycle SETTLE+2.
REQ-023 PRESENT SHALL hold out_valid=1 with out_data, out_slot and out_last stable until out_ready=1; addr SHALL remain unchanged throughout.
REQ-024 On handshake (out_valid & out_ready), if slots remain: addr+1 -> SELECT; otherwise -> TRAILER if enabled, else IDLE.
REQ-025 out_last SHALL be 1 only on the final word of an event, which is the trailer when enabled and otherwise the last slot.
REQ-026 busy SHALL be 1 from the cycle after trig through the cycle of the final handshake, and 0 afterwards.
REQ-027 trig while busy SHALL be ignored and SHALL set overrun; trig in IDLE SHALL be accepted.
REQ-028 clr_ovr=1 SHALL clear overrun; when clr_ovr and an overrunning trig coincide, the set wins.
REQ-029 NSLOTS=1 SHALL produce exactly one slot word with out_last=1 when the trailer is disabled.

Reset
REQ-030 rst SHALL asynchronously force IDLE: addr=8'hFF, out_data=0, out_slot=0, out_valid=0, out_last=0, busy=0, overrun=0, settle counter=0.
REQ-031 rst mid-scan SHALL abort the scan with no trailer, and the scan SHALL NOT resume after release.

Configuration
REQ-032 Macro READOUT_CHECKSUM_EN SHALL select the trailer feature.
REQ-033 With READOUT_CHECKSUM_EN defined: a TRAILER word SHALL follow the last slot, with out_data = XOR of all slot words of the event, out_slot=8'hFE and out_last=1.
REQ-034 Without READOUT_CHECKSUM_EN: there SHALL be no TRAILER state and no checksum register.

Structure
REQ-035 Package readout_pkg SHALL hold the state enum, the constants ADDR_IDLE=8'hFF and SLOT_TRAILER=8'hFE, and the 16-bit word typedef.
REQ-036 One sub-module, readout_settle_timer, SHALL implement the loadable settle down-counter with its done output.

Verification
REQ-037 Scenario 1: defaults; slot k drives 16'h1000+k; out_ready=1 -> 8 words 1000..1007 with out_slot 0..7, first out_valid at cycle 4, out_last on slot 7, busy then 0.
REQ-038 Scenario 2: out_ready held low 5 cycles on slot 3 -> out_data stays 16'h1003 and addr stays 3 throughout, then the scan continues.
REQ-039 Scenario 3: second trig during the scan -> it is ignored and overrun=1; clr_ovr -> overrun=0; the next trig in IDLE is accepted.
REQ-040 Scenario 4: rst asserted while at slot 4 -> all outputs take their reset values immediately; after release addr=8'hFF and no further words are produced.
REQ-041 Scenario 5: READOUT_CHECKSUM_EN, NSLOTS=2, words 16'hA5A5 and 16'h0F0F -> a third word 16'hAAAA with out_slot=8'hFE and out_last=1 only on that word.
REQ-042 Scenario 6: NSLOTS=1, SETTLE=1, checksum disabled -> one word with out_last=1, out_valid at cycle 3.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and constants for the slot readout sequencer.
// READOUT_CHECKSUM_EN adds the TRAILER state carrying the per-event XOR checksum.
package readout_pkg;

  localparam logic [7:0] ADDR_IDLE    = 8'hFF;
  localparam logic [7:0] SLOT_TRAILER = 8'hFE;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SAMPLE,
    PRESENT
`ifdef READOUT_CHECKSUM_EN
    , TRAILER
`endif
  } state_e;

endpackage

// File: rtl/readout_settle_timer.sv
// Loadable down-counter that times the bus settle window after an addr change.
// done_o flags the final settle cycle (count of 1).
module readout_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/readout_sequencer.sv
// Scans NSLOTS slot addresses per trigger, samples the shared bus after a settle
// window and hands each word downstream; READOUT_CHECKSUM_EN appends an XOR trailer.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int NSLOTS     = 8,
  parameter int FIRST_SLOT = 0,
  parameter int SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic        clr_ovr,
  output logic [7:0]  addr,
  input  logic [15:0] bus_data,
  output logic [15:0] out_data,
  output logic [7:0]  out_slot,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overrun
);

  localparam logic [7:0] FIRST_ADDR = 8'(FIRST_SLOT);
  localparam logic [7:0] LAST_ADDR  = 8'(FIRST_SLOT + NSLOTS - 1);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] slot_q, slot_d;
  word_t      data_q, data_d;
  logic       ovr_q, ovr_d;
  logic       tmr_load, tmr_dec, tmr_done;
`ifdef READOUT_CHECKSUM_EN
  word_t      csum_q, csum_d;
`endif

  readout_settle_timer u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_CNT),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    slot_d   = slot_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef READOUT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = SELECT;
          addr_d   = FIRST_ADDR;
          tmr_load = 1'b1;
`ifdef READOUT_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      SELECT: begin
        tmr_dec = 1'b1;
        if (tmr_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        data_d  = bus_data;
        slot_d  = addr_q;
`ifdef READOUT_CHECKSUM_EN
        csum_d  = csum_q ^ bus_data;
`endif
        state_d = PRESENT;
      end
      PRESENT: begin
        // addr holds the current slot until the word is accepted
        if (out_ready) begin
          if (addr_q != LAST_ADDR) begin
            state_d  = SELECT;
            addr_d   = addr_q + 8'd1;
            tmr_load = 1'b1;
          end else begin
            addr_d   = ADDR_IDLE;
`ifdef READOUT_CHECKSUM_EN
            state_d  = TRAILER;
            data_d   = csum_q;
            slot_d   = SLOT_TRAILER;
`else
            state_d  = IDLE;
`endif
          end
        end
      end
`ifdef READOUT_CHECKSUM_EN
      TRAILER: begin
        if (out_ready) state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
        addr_d  = ADDR_IDLE;
      end
    endcase
  end

  // a trigger landing mid-scan is dropped but remembered; set beats clear
  always_comb begin
    ovr_d = ovr_q;
    if (trig && busy) ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= ADDR_IDLE;
      slot_q  <= 8'd0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
`ifdef READOUT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign addr     = addr_q;
  assign out_data = data_q;
  assign out_slot = slot_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = ovr_q;
`ifdef READOUT_CHECKSUM_EN
  assign out_valid = (state_q == PRESENT) || (state_q == TRAILER);
  assign out_last  = (state_q == TRAILER);
`else
  assign out_valid = (state_q == PRESENT);
  assign out_last  = (state_q == PRESENT) && (addr_q == LAST_ADDR);
`endif

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench: three sequencer configurations checked against a hand-built word table.
module tb_readout_sequencer;

`ifdef READOUT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int A0 = 0;
  localparam int NA = 8 + CK;
  localparam int B0 = A0 + NA;
  localparam int NB = 2 + CK;
  localparam int C0 = B0 + NB;
  localparam int NC = 1 + CK;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  s;
    logic        l;
    int          c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  trig, clr, rdy;
  logic [2:0]  vld, last, busy, ovr;
  logic [7:0]  addr [3];
  logic [7:0]  slot [3];
  logic [15:0] data [3];
  logic [15:0] bus  [3];

  int   n_pass = 0, n_tot = 0, cyc = 0;
  vec_t tv [16];

  always #5 clk = ~clk;

  assign bus[0] = (addr[0] < 8'd8) ? 16'h1000 + {8'h00, addr[0]} : 16'hFFFF;
  assign bus[1] = (addr[1] == 8'd0) ? 16'hA5A5 : (addr[1] == 8'd1) ? 16'h0F0F : 16'hFFFF;
  assign bus[2] = (addr[2] == 8'd0) ? 16'h1234 : 16'hFFFF;

  readout_sequencer u_a (
    .clk(clk), .rst(rst), .trig(trig[0]), .clr_ovr(clr[0]), .addr(addr[0]),
    .bus_data(bus[0]), .out_data(data[0]), .out_slot(slot[0]), .out_valid(vld[0]),
    .out_ready(rdy[0]), .out_last(last[0]), .busy(busy[0]), .overrun(ovr[0]));

  readout_sequencer #(.NSLOTS(2), .SETTLE(1)) u_b (
    .clk(clk), .rst(rst), .trig(trig[1]), .clr_ovr(clr[1]), .addr(addr[1]),
    .bus_data(bus[1]), .out_data(data[1]), .out_slot(slot[1]), .out_valid(vld[1]),
    .out_ready(rdy[1]), .out_last(last[1]), .busy(busy[1]), .overrun(ovr[1]));

  readout_sequencer #(.NSLOTS(1), .SETTLE(1)) u_c (
    .clk(clk), .rst(rst), .trig(trig[2]), .clr_ovr(clr[2]), .addr(addr[2]),
    .bus_data(bus[2]), .out_data(data[2]), .out_slot(slot[2]), .out_valid(vld[2]),
    .out_ready(rdy[2]), .out_last(last[2]), .busy(busy[2]), .overrun(ovr[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wait_valid(input int u, input string name);
    int g = 0;
    while (!vld[u] && g < 60) begin tick(); g++; end
    if (g >= 60) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic drain(input int u);
    int g = 0;
    rdy[u] = 1'b1;
    while (busy[u] && g < 300) begin tick(); g++; end
    chk($sformatf("drain%0d_busy", u), busy[u], 0);
  endtask

  task automatic scan(input int u, input int first, input int n);
    cyc = 0;
    rdy[u] = 1'b1;
    trig[u] = 1'b1; tick(); trig[u] = 1'b0;
    chk($sformatf("u%0d_busy_start", u), busy[u], 1);
    chk($sformatf("u%0d_addr_start", u), addr[u], 0);
    for (int i = 0; i < n; i++) begin
      wait_valid(u, $sformatf("u%0d_w%0d", u, i));
      chk($sformatf("u%0d_w%0d_cycle", u, i), cyc, tv[first+i].c);
      chk($sformatf("u%0d_w%0d_data", u, i), data[u], tv[first+i].d);
      chk($sformatf("u%0d_w%0d_slot", u, i), slot[u], tv[first+i].s);
      chk($sformatf("u%0d_w%0d_last", u, i), last[u], tv[first+i].l);
      tick();
    end
    chk($sformatf("u%0d_busy_end", u), busy[u], 0);
    chk($sformatf("u%0d_addr_end", u), addr[u], 8'hFF);
  endtask

  initial begin
    int nv;
    for (int k = 0; k < 8; k++)
      tv[A0+k] = '{16'h1000 + 16'(k), 8'(k), 1'((k == 7) && (CK == 0)), 4 + 4*k};
    tv[B0]   = '{16'hA5A5, 8'd0, 1'b0, 3};
    tv[B0+1] = '{16'h0F0F, 8'd1, 1'(CK == 0), 6};
    tv[C0]   = '{16'h1234, 8'd0, 1'(CK == 0), 3};
`ifdef READOUT_CHECKSUM_EN
    tv[A0+8] = '{16'h0000, 8'hFE, 1'b1, 33};
    tv[B0+2] = '{16'hAAAA, 8'hFE, 1'b1, 7};
    tv[C0+1] = '{16'h1234, 8'hFE, 1'b1, 4};
`endif

    trig = '0; clr = '0; rdy = '1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr[0], 8'hFF);
    chk("rst_data", data[0], 0);
    chk("rst_slot", slot[0], 0);
    chk("rst_valid", vld, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_addr_b", addr[1], 8'hFF);
    chk("rst_addr_c", addr[2], 8'hFF);
    rst = 1'b0;
    tick();

    // basic scan, then the small configurations
    scan(0, A0, NA);
    scan(1, B0, NB);
    scan(2, C0, NC);

    // backpressure on slot 3
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    begin
      int g = 0;
      while (!(vld[0] && slot[0] == 8'd3) && g < 60) begin tick(); g++; end
      if (g >= 60) chk("bp_reach_timeout", 0, 1);
    end
    rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d_data", i), data[0], 16'h1003);
      chk($sformatf("bp_hold%0d_addr", i), addr[0], 8'd3);
      chk($sformatf("bp_hold%0d_valid", i), vld[0], 1);
    end
    rdy[0] = 1'b1;
    tick();
    wait_valid(0, "bp_next");
    chk("bp_next_slot", slot[0], 8'd4);
    chk("bp_next_data", data[0], 16'h1004);
    drain(0);

    // overrun: trigger while busy, coincident clear, clear, fresh accept
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    tick(); tick();
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    chk("ovr_set", ovr[0], 1);
    chk("ovr_scan_addr", addr[0], 8'd0);
    chk("ovr_scan_valid", vld[0], 1);
    trig[0] = 1'b1; clr[0] = 1'b1; tick(); trig[0] = 1'b0; clr[0] = 1'b0;
    chk("ovr_set_wins", ovr[0], 1);
    drain(0);
    chk("ovr_sticky", ovr[0], 1);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    chk("ovr_clr", ovr[0], 0);
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    chk("idle_trig_busy", busy[0], 1);
    chk("idle_trig_ovr", ovr[0], 0);
    drain(0);

    // reset mid-scan at slot 4
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    begin
      int g = 0;
      while (!(vld[0] && slot[0] == 8'd4) && g < 60) begin tick(); g++; end
      if (g >= 60) chk("rst4_reach_timeout", 0, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst4_addr", addr[0], 8'hFF);
    chk("rst4_data", data[0], 0);
    chk("rst4_slot", slot[0], 0);
    chk("rst4_valid", vld[0], 0);
    chk("rst4_last", last[0], 0);
    chk("rst4_busy", busy[0], 0);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vld[0]) nv++;
    end
    chk("rst4_no_words", nv, 0);
    chk("rst4_addr_after", addr[0], 8'hFF);
    chk("rst4_busy_after", busy[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
